// File: rtl/vga_reg_writer.sv
// vga_reg_writer: FIFO-buffered Avalon-MM write master that drains committed register updates as a burst.
// Define VGA_REG_WRITER_VBLANK_GATE_EN to hold each drain until the vblank rising edge and flag tearing.
module vga_reg_writer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              cmd_commit,
  input  logic              vblank,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [ADDR_W-1:0] avm_address,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic              avm_waitrequest,
  output logic              busy,
  output logic              frame_done,
  output logic              tear
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  typedef enum logic [1:0] {IDLE, WAIT_VB, ISSUE, DONE} state_t;
  state_t state;
  logic [PW-1:0] wr_ptr, rd_ptr, commit_ptr, end_ptr, rd_nxt;
  logic [ADDR_W+DATA_W-1:0] mem [DEPTH];
  logic full, push, pending, launch;
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  assign rd_nxt    = rd_ptr + PW'(1);
  assign pending   = commit_ptr != rd_ptr;
  assign busy      = state != IDLE;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= {cmd_addr, cmd_data};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + PW'(1);
      if (cmd_commit) commit_ptr <= wr_ptr + PW'(1);
    end
`ifdef VGA_REG_WRITER_VBLANK_GATE_EN
  logic vblank_q;
  assign launch = state == WAIT_VB && vblank && !vblank_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      vblank_q <= 1'b0;
      tear     <= 1'b0;
    end else begin
      vblank_q <= vblank;
      if (state == ISSUE && !vblank && vblank_q) tear <= 1'b1;
    end
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign launch        = state == IDLE && pending;
  assign tear          = 1'b0;
`endif
  // end_ptr freezes the batch; commits landing after launch wait for the next drain
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state          <= IDLE;
      rd_ptr         <= '0;
      end_ptr        <= '0;
      avm_write      <= 1'b0;
      avm_chipselect <= 1'b0;
      avm_address    <= '0;
      avm_writedata  <= '0;
      frame_done     <= 1'b0;
    end else if (launch) begin
      state                         <= ISSUE;
      end_ptr                       <= commit_ptr;
      avm_write                     <= 1'b1;
      avm_chipselect                <= 1'b1;
      {avm_address, avm_writedata}  <= mem[rd_ptr[AW-1:0]];
    end else begin
      case (state)
        IDLE: if (pending) state <= WAIT_VB;
        ISSUE: if (!avm_waitrequest) begin
          rd_ptr <= rd_nxt;
          if (rd_nxt == end_ptr) begin
            state          <= DONE;
            avm_write      <= 1'b0;
            avm_chipselect <= 1'b0;
            frame_done     <= 1'b1;
          end else {avm_address, avm_writedata} <= mem[rd_nxt[AW-1:0]];
        end
        DONE: begin
          frame_done <= 1'b0;
          state      <= IDLE;
        end
        default: ;
      endcase
    end
endmodule

// File: doc/vga_reg_writer.md
# vga_reg_writer

Avalon-MM write master that feeds the VGA sprite/boundary register peripheral. Game-side logic pushes (address, data) register updates into an internal FIFO and marks the last update of each frame with a commit flag. At the start of vertical blanking, the block drains all committed updates as back-to-back Avalon writes, so boundary and sprite registers never change mid-frame.

## Interface
Parameters:
- DEPTH, 16: FIFO entries; must be a power of two, at least 2.
- ADDR_W, 6: register address width; matches the peripheral's address port.
- DATA_W, 16: write data width; matches the peripheral's writedata port.

Ports:
- clk, input, 1: system clock (50 MHz, same clock as the display peripheral).
- reset, input, 1: asynchronous, active-high.
- cmd_valid, input, 1: a command is offered on cmd_addr, cmd_data and cmd_commit.
- cmd_ready, output, 1: the FIFO can accept a command (equals !full).
- cmd_addr, input, ADDR_W: target register address.
- cmd_data, input, DATA_W: value to write.
- cmd_commit, input, 1: this command closes a frame batch.
- vblank, input, 1: high during vertical blanking (vcount ≥ 480). Synchronous to clk.
- avm_chipselect, output, 1: asserted together with avm_write.
- avm_write, output, 1: write request.
- avm_address, output, ADDR_W: write address.
- avm_writedata, output, DATA_W: write data.
- avm_waitrequest, input, 1: slave stall; tie to 0 for the current peripheral.
- busy, output, 1: the FSM is not in IDLE.
- frame_done, output, 1: one-cycle pulse after the last write of a drain is accepted.
- tear, output, 1: sticky flag; set when vblank falls while a drain is still in progress. Cleared only by reset.

## Operation
- FIFO:
  - A push happens when cmd_valid && cmd_ready. A push when full is ignored, including its commit flag.
  - A push and a pop in the same cycle are both legal; the occupancy count is unchanged.
  - Pointers are log2(DEPTH)+1 bits wide and wrap modulo 2·DEPTH. full and empty are derived from the MSB compare.
- Commit pointer:
  - An accepted push with cmd_commit=1 sets commit_ptr to the new write pointer (wr_ptr+1).
  - Uncommitted entries are never drained.
- FSM states: IDLE, WAIT_VB, ISSUE, DONE.
  - IDLE → WAIT_VB when commit_ptr ≠ rd_ptr.
  - WAIT_VB → ISSUE on the vblank rising edge (vblank && !vblank_q). At this point end_ptr latches commit_ptr.
    - If vblank is already high when the FSM enters WAIT_VB, it waits for the next rising edge.
    - Commits that arrive after end_ptr is latched are served in the next frame.
  - ISSUE:
    - avm_write, avm_chipselect, avm_address and avm_writedata come from the FIFO head (all registered).
    - When avm_waitrequest is 0, the write is accepted and rd_ptr increments.
    - If the new rd_ptr equals end_ptr, go to DONE. Otherwise present the next entry in the following cycle, with no idle gap.
  - DONE: frame_done=1 for one cycle, then → IDLE.
- tear is set in any cycle where the state is ISSUE and a vblank falling edge is seen. The drain still completes; it is never aborted.
- Reset, asynchronous, including mid-drain:
  - FIFO is flushed (pointers 0); commit_ptr and end_ptr are 0.
  - State is IDLE; vblank_q is 0.
  - Output values during reset: all avm_* 0, busy 0, frame_done 0, tear 0, cmd_ready 1.
  - An in-flight write is dropped. This is acceptable because the peripheral shares the reset.

## Timing
- The vblank rising edge is detected at cycle N. avm_write is first high at N+1.
- With avm_waitrequest=0, a K-entry batch occupies cycles N+1 through N+K. frame_done is high at N+K+1.
- While avm_waitrequest=1, address, data and write hold stable. The write completes in the first cycle avm_waitrequest is 0.
- A push becomes visible to the drain logic one cycle after acceptance.
- cmd_ready is combinational from occupancy. It falls in the cycle after the push that fills the FIFO.
- Drain worst case is DEPTH cycles, far shorter than the vblank period of 45 lines × 1600 clocks.

## Configuration
- VGA_REG_WRITER_VBLANK_GATE_EN
  - Defined: behaviour is as above; draining waits for the vblank rising edge.
  - Undefined:
    - WAIT_VB is skipped and the vblank input is ignored.
    - IDLE → ISSUE directly when commit_ptr ≠ rd_ptr; end_ptr latches on that transition.
    - tear is tied to 0.
    - The first write appears 2 cycles after the committing push.

## Test plan
- Basic batch:
  - Stimulus: push (0x4, 0x0A0), (0x5, 0x0C1), then (0x6, 0x001) with commit while vblank is low; raise vblank at cycle N; waitrequest held 0.
  - Required: writes to addresses 4, 5, 6 with those data at N+1, N+2, N+3; frame_done at N+4; busy is 0 at N+5.
- Uncommitted hold:
  - Stimulus: push 3 entries with no commit; toggle vblank twice.
  - Required: no avm_write. Then push a committed 4th entry and raise vblank: 4 writes occur.
- Backpressure:
  - Stimulus: waitrequest high for 3 cycles during the 2nd write.
  - Required: address and data stable for those cycles; total batch spans K+3 cycles; no write is lost or duplicated.
- Full FIFO (DEPTH=16):
  - Stimulus: push 17 commands, the last with commit, without any drain.
  - Required: cmd_ready=0 after the 16th; the 17th is dropped, so commit_ptr is unchanged and 0 entries are drained.
- Tear:
  - Stimulus: waitrequest held high while vblank falls in ISSUE.
  - Required: tear becomes 1 and stays 1; the drain completes after waitrequest drops.
- Reset mid-drain:
  - Stimulus: assert reset during the 2nd of 5 writes.
  - Required: avm_write is 0 immediately; after release, FIFO is empty, cmd_ready=1, and the next vblank produces no write.
